// File: rtl/uplink_arb_if.sv
// Uplink arbiter bundle: two 4-phase child ports, one parent port, status.
// The arbiter takes the master view; the surrounding fabric takes the slave view.
interface uplink_arb_if #(
    parameter int WIDTH = 11
);
    logic             c1_req;
    logic [WIDTH-1:0] c1_data;
    logic             c1_ack;
    logic             c2_req;
    logic [WIDTH-1:0] c2_data;
    logic             c2_ack;
    logic             p_req;
    logic [WIDTH-1:0] p_data;
    logic             p_ack;
    logic [1:0]       gnt;
    logic             err;

    modport master (
        input  c1_req, c1_data, c2_req, c2_data, p_ack,
        output c1_ack, c2_ack, p_req, p_data, gnt, err
    );

    modport slave (
        output c1_req, c1_data, c2_req, c2_data, p_ack,
        input  c1_ack, c2_ack, p_req, p_data, gnt, err
    );
endinterface

// File: rtl/uplink_arb.sv
// Two-child round-robin 4-phase uplink arbiter, one packet in flight.
// Define UPLINK_ARB_TIMEOUT_EN to abort SEND after TIMEOUT cycles without p_ack.
module uplink_arb #(
    parameter int WIDTH   = 11,
    parameter int TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      rst_n,
    uplink_arb_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RELEASE,
        CACK
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       gnt_q;
    logic             p_req_q;
    logic             c1_ack_q;
    logic             c2_ack_q;
    logic             last_c2;
    logic             any_req;
    logic             pick_c1;
    logic             gnt_req;

`ifdef UPLINK_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;
    logic          err_q;
`endif

    // c1 wins a tie only when c2 held the last grant
    always_comb begin
        any_req = bus.c1_req | bus.c2_req;
        pick_c1 = bus.c1_req & (~bus.c2_req | last_c2);
        gnt_req = gnt_q[0] ? bus.c1_req : bus.c2_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_q   <= '0;
            gnt_q    <= 2'b00;
            p_req_q  <= 1'b0;
            c1_ack_q <= 1'b0;
            c2_ack_q <= 1'b0;
            last_c2  <= 1'b1;
`ifdef UPLINK_ARB_TIMEOUT_EN
            cnt      <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state   <= SEND;
                        p_req_q <= 1'b1;
                        data_q  <= pick_c1 ? bus.c1_data : bus.c2_data;
                        gnt_q   <= pick_c1 ? 2'b01 : 2'b10;
`ifdef UPLINK_ARB_TIMEOUT_EN
                        cnt     <= '0;
`endif
                    end
                end
                SEND: begin
                    if (bus.p_ack) begin
                        state   <= RELEASE;
                        p_req_q <= 1'b0;
                    end
`ifdef UPLINK_ARB_TIMEOUT_EN
                    // parent unresponsive: drop packet, still release the child
                    else if (cnt == TMAX) begin
                        state    <= CACK;
                        p_req_q  <= 1'b0;
                        err_q    <= 1'b1;
                        c1_ack_q <= gnt_q[0];
                        c2_ack_q <= gnt_q[1];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RELEASE: begin
                    if (!bus.p_ack) begin
                        state    <= CACK;
                        c1_ack_q <= gnt_q[0];
                        c2_ack_q <= gnt_q[1];
                    end
                end
                CACK: begin
                    if (!gnt_req) begin
                        state    <= IDLE;
                        c1_ack_q <= 1'b0;
                        c2_ack_q <= 1'b0;
                        gnt_q    <= 2'b00;
                        last_c2  <= gnt_q[1];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.p_req  = p_req_q;
    assign bus.p_data = data_q;
    assign bus.gnt    = gnt_q;
    assign bus.c1_ack = c1_ack_q;
    assign bus.c2_ack = c2_ack_q;
`ifdef UPLINK_ARB_TIMEOUT_EN
    assign bus.err    = err_q;
`else
    assign bus.err    = 1'b0;
`endif
endmodule

// File: tb/tb_uplink_arb.sv
// Scoreboard bench for uplink_arb: child/parent models run at negedge,
// expected packets queued at stimulus time and compared when p_req rises.
module tb_uplink_arb;
    localparam int W = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uplink_arb_if #(.WIDTH(W)) bus ();

    uplink_arb #(
        .WIDTH  (W),
        .TIMEOUT(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic         c1_req = 1'b0;
    logic         c2_req = 1'b0;
    logic         p_ack = 1'b0;
    logic [W-1:0] c1_data = '0;
    logic [W-1:0] c2_data = '0;

    assign bus.c1_req  = c1_req;
    assign bus.c2_req  = c2_req;
    assign bus.c1_data = c1_data;
    assign bus.c2_data = c2_data;
    assign bus.p_ack   = p_ack;

    typedef struct {
        logic [1:0]   gnt;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] c1_q[$];
    logic [W-1:0] c2_q[$];
    int           n_chk = 0;
    int           n_pass = 0;
    int           c1_done = 0;
    int           c2_done = 0;
    int           p_cnt = 0;
    int           p_delay = 0;
    bit           p_never = 1'b0;
    logic [W-1:0] p_hold = '0;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic expect_pkt(input logic [1:0] g, input logic [W-1:0] d);
        exp_t e;
        e.gnt  = g;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        check("ack_gnt", 16'({bus.c2_ack, bus.c1_ack} & ~bus.gnt), 16'h0);
        // parent model
        if (bus.p_req && !p_ack) begin
            if (p_cnt == 0) begin
                if (exp_q.size() == 0) begin
                    check("sb_size", 16'(exp_q.size()), 16'h1);
                end else begin
                    e = exp_q.pop_front();
                    check("p_data", 16'(bus.p_data), 16'(e.data));
                    check("gnt", 16'(bus.gnt), 16'(e.gnt));
                    p_hold = bus.p_data;
                end
            end else begin
                check("p_hold", 16'(bus.p_data), 16'(p_hold));
            end
            if (!p_never && p_cnt >= p_delay) p_ack = 1'b1;
            p_cnt++;
        end else if (!bus.p_req) begin
            p_ack = 1'b0;
            p_cnt = 0;
        end
        // child models
        if (c1_req && bus.c1_ack) begin
            c1_req = 1'b0;
            void'(c1_q.pop_front());
            c1_done++;
        end else if (!c1_req && !bus.c1_ack && c1_q.size() > 0) begin
            c1_req  = 1'b1;
            c1_data = c1_q[0];
        end
        if (c2_req && bus.c2_ack) begin
            c2_req = 1'b0;
            void'(c2_q.pop_front());
            c2_done++;
        end else if (!c2_req && !bus.c2_ack && c2_q.size() > 0) begin
            c2_req  = 1'b1;
            c2_data = c2_q[0];
        end
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        while (n < max && !(c1_q.size() == 0 && c2_q.size() == 0 &&
               !c1_req && !c2_req && bus.gnt == 2'b00 && !bus.p_req &&
               exp_q.size() == 0)) begin
            tick();
            n++;
        end
        check("idle_wait", 16'(n < max), 16'h1);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        c1_req  = 1'b0;
        c2_req  = 1'b0;
        p_ack   = 1'b0;
        p_cnt   = 0;
        p_never = 1'b0;
        c1_q.delete();
        c2_q.delete();
        exp_q.delete();
        repeat (2) tick();
        check("rst_p_req", 16'(bus.p_req), 16'h0);
        check("rst_gnt", 16'(bus.gnt), 16'h0);
        check("rst_acks", 16'({bus.c2_ack, bus.c1_ack}), 16'h0);
        check("rst_p_data", 16'(bus.p_data), 16'h0);
        check("rst_err", 16'(bus.err), 16'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int c1_before;

        do_reset();

        // single c1 packet, parent acks one cycle late
        p_delay = 1;
        c1_q.push_back(11'h000);
        expect_pkt(2'b01, 11'h000);
        run_idle(50);
        check("single_gnt_after", 16'(bus.gnt), 16'h0);
        check("single_c1_done", 16'(c1_done), 16'd1);
        check("single_c2_done", 16'(c2_done), 16'd0);

        // simultaneous contest right after reset: c1 first
        do_reset();
        p_delay = 0;
        c1_q.push_back(11'h7FF);
        c2_q.push_back(11'h000);
        expect_pkt(2'b01, 11'h7FF);
        expect_pkt(2'b10, 11'h000);
        run_idle(50);
        check("tie_c1_done", 16'(c1_done), 16'd2);
        check("tie_c2_done", 16'(c2_done), 16'd1);

        // both hold req for four packets: strict alternation
        c1_q.push_back(11'h111);
        c1_q.push_back(11'h222);
        c2_q.push_back(11'h333);
        c2_q.push_back(11'h444);
        expect_pkt(2'b01, 11'h111);
        expect_pkt(2'b10, 11'h333);
        expect_pkt(2'b01, 11'h222);
        expect_pkt(2'b10, 11'h444);
        run_idle(100);
        check("rr_c1_done", 16'(c1_done), 16'd4);
        check("rr_c2_done", 16'(c2_done), 16'd3);

        // slow parent: data and request held across the wait
        p_delay = 10;
        c2_q.push_back(11'h2AA);
        expect_pkt(2'b10, 11'h2AA);
        run_idle(80);
        check("slow_c2_done", 16'(c2_done), 16'd4);

        // parent never acks
        p_delay = 0;
        p_never = 1'b1;
        c1_q.push_back(11'h155);
        expect_pkt(2'b01, 11'h155);
        repeat (40) tick();
`ifdef UPLINK_ARB_TIMEOUT_EN
        check("to_err", 16'(bus.err), 16'h1);
        check("to_p_req", 16'(bus.p_req), 16'h0);
        check("to_c1_done", 16'(c1_done), 16'd5);
        p_never = 1'b0;
        c1_q.push_back(11'h0AB);
        expect_pkt(2'b01, 11'h0AB);
        run_idle(50);
        check("to_err_sticky", 16'(bus.err), 16'h1);
        check("to_next_done", 16'(c1_done), 16'd6);
`else
        check("hang_p_req", 16'(bus.p_req), 16'h1);
        check("hang_err", 16'(bus.err), 16'h0);
        check("hang_c1_ack", 16'(bus.c1_ack), 16'h0);
        p_never = 1'b0;
        run_idle(20);
        check("hang_c1_done", 16'(c1_done), 16'd5);
        check("hang_err_after", 16'(bus.err), 16'h0);
`endif

        // asynchronous reset in the middle of SEND
        p_never = 1'b1;
        c1_q.push_back(11'h0F0);
        expect_pkt(2'b01, 11'h0F0);
        repeat (4) tick();
        check("mid_p_req", 16'(bus.p_req), 16'h1);
        c1_before = c1_done;
        #2 rst_n = 1'b0;
        #1;
        check("async_p_req", 16'(bus.p_req), 16'h0);
        check("async_gnt", 16'(bus.gnt), 16'h0);
        check("async_c1_ack", 16'(bus.c1_ack), 16'h0);
        check("async_p_data", 16'(bus.p_data), 16'h0);
        check("async_err", 16'(bus.err), 16'h0);
        do_reset();
        check("abort_no_ack", 16'(c1_done), 16'(c1_before));
        c1_q.push_back(11'h0C1);
        c2_q.push_back(11'h0C2);
        expect_pkt(2'b01, 11'h0C1);
        expect_pkt(2'b10, 11'h0C2);
        run_idle(50);
        check("post_c1_done", 16'(c1_done), 16'(c1_before + 1));
        check("post_c2_done", 16'(c2_done), 16'd5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
